// File: rtl/bcd_digit_serial_ctrl.sv
// Digit-serial BCD add/sub sequencer driving one shared single-digit adder.
// Optional subtraction (10's complement) enabled with `define BCD_SUB_EN.
module bcd_digit_serial_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic [4*NDIG-1:0] a_bcd,
  input  logic [4*NDIG-1:0] b_bcd,
  input  logic              cin,
`ifdef BCD_SUB_EN
  input  logic              op,
`endif
  output logic [3:0]        add_x,
  output logic [3:0]        add_y,
  output logic              add_cin,
  input  logic [3:0]        add_s,
  input  logic              add_cout,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              cout,
  output logic              err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [4*NDIG-1:0] a_q, a_d;
  logic [4*NDIG-1:0] b_q, b_d;
  logic [4*NDIG-1:0] result_q, result_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;
  logic              op_q, op_d;
  logic              op_in;
  logic [3:0]        dig_a;
  logic [3:0]        dig_b;

`ifdef BCD_SUB_EN
  assign op_in = op;
`else
  assign op_in = 1'b0;
`endif

  function automatic logic has_bad(input logic [4*NDIG-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // select the current operand digit pair
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  // next-state, datapath updates and adder drive
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    err_d    = err_q;
    op_d     = op_q;
    add_x    = 4'd0;
    add_y    = 4'd0;
    add_cin  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ADD;
          a_d      = a_bcd;
          b_d      = b_bcd;
          op_d     = op_in;
          idx_d    = '0;
          carry_d  = op_in ? 1'b1 : cin;
          result_d = '0;
          cout_d   = 1'b0;
          err_d    = has_bad(a_bcd) | has_bad(b_bcd);
        end
      end
      S_ADD: begin
        add_x   = dig_a;
        add_y   = op_q ? (4'd9 - dig_b) : dig_b;
        add_cin = carry_q;
        for (int i = 0; i < NDIG; i++) begin
          if (idx_q == IW'(i)) result_d[4*i +: 4] = add_s;
        end
        carry_d = add_cout;
        if (idx_q == LAST) begin
          state_d = S_DONE;
          cout_d  = add_cout;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
      op_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
      op_q     <= op_d;
    end
  end

  assign busy   = (state_q == S_ADD);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign err    = err_q;

endmodule
